// File: rtl/data_mem_responder_pkg.sv
// Shared types and helpers for the wait-state data memory responder.
package data_mem_responder_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned ADDR_W = 32;
   localparam int unsigned CNT_W  = 4;

   // FSM state encoding
   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_WAIT = 2'b01,
      ST_RESP = 2'b10
   } state_t;

   // Access direction
   typedef enum logic {
      RW_RD = 1'b0,
      RW_WR = 1'b1
   } rw_t;

   // Request payload held for the duration of an access
   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      rw_t               rw;
      logic [DATA_W-1:0] data;
   } req_t;

   // Word index width for a given depth (at least one bit)
   function automatic int unsigned idx_width(input int unsigned depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   // A request is rejected when misaligned or beyond the last stored word
   function automatic logic addr_err(input logic [ADDR_W-1:0] addr,
                                     input int unsigned       depth);
      return (addr[1:0] != 2'b00) || ({2'b00, addr[ADDR_W-1:2]} >= depth);
   endfunction

endpackage

// File: rtl/data_mem_array.sv
// Word array: synchronous write, registered read, storage never reset.
module data_mem_array
   import data_mem_responder_pkg::*;
#(
   parameter int unsigned DEPTH = 64,
   parameter int unsigned IDX_W = 6
) (
   input  logic              i_clk,
   input  logic              i_we,
   input  logic              i_re,
   input  logic [IDX_W-1:0]  i_idx,
   input  logic [DATA_W-1:0] i_wdata,
   output logic [DATA_W-1:0] o_rdata
);

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [DATA_W-1:0] r_rdata;

   // Commit write data to the addressed word
   always_ff @(posedge i_clk) begin
      if (i_we) begin
         r_mem[i_idx] <= i_wdata;
      end
   end

   // Capture read data; holds its value between reads
   always_ff @(posedge i_clk) begin
      if (i_re) begin
         r_rdata <= r_mem[i_idx];
      end
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/data_mem_responder.sv
// Request/acknowledge data memory with programmable wait states and
// address checking. Ack/Err/Busy come straight from flops.
module data_mem_responder
   import data_mem_responder_pkg::*;
#(
   parameter int unsigned DEPTH       = 64,
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              Req,
   input  logic              RW,
   input  logic [ADDR_W-1:0] Addr,
   input  logic [DATA_W-1:0] DataIn,
   output logic              Ack,
   output logic [DATA_W-1:0] DataOut,
   output logic              Err,
   output logic              Busy
);

   localparam int unsigned IDX_W = idx_width(DEPTH);

   state_t             r_state;
   state_t             w_next_state;
   logic [CNT_W-1:0]   r_cnt;
   logic [CNT_W-1:0]   w_next_cnt;
   logic               w_accept;

   req_t               r_req;
   req_t               w_cur_req;
   logic               w_bad;
   logic               w_enter_resp;
   logic               w_we;
   logic               w_re;

   logic               r_ack;
   logic               r_err;
   logic               r_busy;
   logic               r_have_rd;
   logic [DATA_W-1:0]  w_rdata;

   // Next state and wait counter
   always_comb begin
      w_next_state = r_state;
      w_next_cnt   = r_cnt;
      w_accept     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (Req) begin
               w_accept = 1'b1;
               if (WAIT_CYCLES == 0) begin
                  w_next_state = ST_RESP;
                  w_next_cnt   = '0;
               end else begin
                  w_next_state = ST_WAIT;
                  w_next_cnt   = CNT_W'(WAIT_CYCLES);
               end
            end
         end
         ST_WAIT: begin
            // Leaving on the edge that takes the counter from 1 to 0
            if (r_cnt <= CNT_W'(1)) begin
               w_next_state = ST_RESP;
               w_next_cnt   = '0;
            end else begin
               w_next_cnt   = r_cnt - CNT_W'(1);
            end
         end
         ST_RESP: begin
            w_next_state = ST_IDLE;
         end
         default: begin
            w_next_state = ST_IDLE;
            w_next_cnt   = '0;
         end
      endcase
   end

   // Request being served: live inputs when going IDLE->RESP directly,
   // otherwise the copy captured at acceptance
   always_comb begin
      w_cur_req = r_req;
      if (r_state == ST_IDLE) begin
         w_cur_req.addr = Addr;
         w_cur_req.rw   = rw_t'(RW);
         w_cur_req.data = DataIn;
      end
   end

   // Memory strobes fire only on the edge that enters RESP, and never
   // while reset is held since the array itself has no reset
   always_comb begin
      w_bad        = addr_err(w_cur_req.addr, DEPTH);
      w_enter_resp = (w_next_state == ST_RESP) && (r_state != ST_RESP);
      w_we         = RST && w_enter_resp && !w_bad && (w_cur_req.rw == RW_WR);
      w_re         = RST && w_enter_resp && !w_bad && (w_cur_req.rw == RW_RD);
   end

   // State, counter, latched request and registered status outputs
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_state   <= ST_IDLE;
         r_cnt     <= '0;
         r_req     <= '0;
         r_ack     <= 1'b0;
         r_err     <= 1'b0;
         r_busy    <= 1'b0;
         r_have_rd <= 1'b0;
      end else begin
         r_state <= w_next_state;
         r_cnt   <= w_next_cnt;
         if (w_accept) begin
            r_req <= w_cur_req;
         end
         r_ack  <= w_enter_resp;
         r_err  <= w_enter_resp && w_bad;
         r_busy <= (w_next_state != ST_IDLE);
         if (w_re) begin
            r_have_rd <= 1'b1;
         end
      end
   end

   data_mem_array #(
      .DEPTH (DEPTH),
      .IDX_W (IDX_W)
   ) u_array (
      .i_clk   (CLK),
      .i_we    (w_we),
      .i_re    (w_re),
      .i_idx   (w_cur_req.addr[2 +: IDX_W]),
      .i_wdata (w_cur_req.data),
      .o_rdata (w_rdata)
   );

   // Read data is masked to zero from reset until the first valid read,
   // because the read register inside the array keeps no reset
   assign DataOut = r_have_rd ? w_rdata : '0;
   assign Ack     = r_ack;
   assign Err     = r_err;
   assign Busy    = r_busy;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: one instance with two wait
// states and one with none.
module tb_data_mem_responder;

   logic        clk = 1'b0;
   logic        rw = 1'b0;
   logic [31:0] addr = '0;
   logic [31:0] din = '0;

   logic        req_a = 1'b0, rst_a = 1'b0;
   logic        ack_a, err_a, busy_a;
   logic [31:0] dout_a;

   logic        req_b = 1'b0, rst_b = 1'b0;
   logic        ack_b, err_b, busy_b;
   logic [31:0] dout_b;

   int n_chk = 0;
   int n_err = 0;

   logic [1:7] exp_busy = 7'b1110111;
   logic [1:7] exp_ack  = 7'b0010001;

   always #5 clk = ~clk;

   data_mem_responder #(.DEPTH(64), .WAIT_CYCLES(2)) dut_a (
      .CLK(clk), .RST(rst_a), .Req(req_a), .RW(rw), .Addr(addr), .DataIn(din),
      .Ack(ack_a), .DataOut(dout_a), .Err(err_a), .Busy(busy_a));

   data_mem_responder #(.DEPTH(64), .WAIT_CYCLES(0)) dut_b (
      .CLK(clk), .RST(rst_b), .Req(req_b), .RW(rw), .Addr(addr), .DataIn(din),
      .Ack(ack_b), .DataOut(dout_b), .Err(err_b), .Busy(busy_b));

   task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h want 0x%08h", tag, act, exp);
      end
   endtask

   // One complete access; lat counts cycles from the accepting cycle to Ack
   task automatic acc(input bit sel, input logic wr, input logic [31:0] a,
                      input logic [31:0] d, input logic exp_err,
                      input logic [31:0] exp_dout, input string tag);
      int          cyc;
      logic        ak;
      logic        er;
      logic [31:0] dq;
      @(negedge clk);
      rw = wr; addr = a; din = d;
      if (sel) req_b = 1'b1; else req_a = 1'b1;
      @(negedge clk);
      req_a = 1'b0; req_b = 1'b0;
      rw = ~wr; addr = a ^ 32'h0000_0004; din = ~d;
      cyc = 1;
      ak = sel ? ack_b : ack_a;
      while (!ak && cyc < 40) begin
         @(negedge clk);
         cyc++;
         ak = sel ? ack_b : ack_a;
      end
      er = sel ? err_b : err_a;
      dq = sel ? dout_b : dout_a;
      chk_eq({tag, ".lat"}, 32'(cyc), sel ? 32'd1 : 32'd3);
      chk_eq({tag, ".err"}, 32'(er), 32'(exp_err));
      chk_eq({tag, ".dout"}, dq, exp_dout);
      @(negedge clk);
      chk_eq({tag, ".after"}, sel ? {30'd0, ack_b, busy_b} : {30'd0, ack_a, busy_a}, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      #12;
      chk_eq("rst.ack",  32'(ack_a),  32'd0);
      chk_eq("rst.err",  32'(err_a),  32'd0);
      chk_eq("rst.busy", 32'(busy_a), 32'd0);
      chk_eq("rst.dout", dout_a,      32'd0);
      @(negedge clk);
      rst_a = 1'b1; rst_b = 1'b1;

      // Write then read back
      acc(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0, 32'h0,         "wr10");
      acc(0, 1'b0, 32'h10, 32'h0,         1'b0, 32'hDEAD_BEEF, "rd10");

      // Misaligned write leaves word 1 intact
      acc(0, 1'b1, 32'h4,  32'h1111_2222, 1'b0, 32'hDEAD_BEEF, "wr04");
      acc(0, 1'b1, 32'h6,  32'h1234_5678, 1'b1, 32'hDEAD_BEEF, "wr06mis");
      acc(0, 1'b0, 32'h4,  32'h0,         1'b0, 32'h1111_2222, "rd04");

      // Out of range read, then the last legal word
      acc(0, 1'b0, 32'h100, 32'h0,        1'b1, 32'h1111_2222, "rd100oor");
      acc(0, 1'b1, 32'hFC, 32'h0BAD_F00D, 1'b0, 32'h1111_2222, "wrFC");
      acc(0, 1'b0, 32'hFC, 32'h0,         1'b0, 32'h0BAD_F00D, "rdFC");

      // Back-to-back with Req held and Addr changed while busy
      acc(0, 1'b1, 32'h8,  32'hCAFE_0008, 1'b0, 32'h0BAD_F00D, "wr08");
      acc(0, 1'b1, 32'hC,  32'hCAFE_000C, 1'b0, 32'h0BAD_F00D, "wr0C");
      @(negedge clk);
      rw = 1'b0; addr = 32'h8; req_a = 1'b1;
      for (int i = 1; i <= 7; i++) begin
         @(negedge clk);
         if (i == 1) addr = 32'hC;
         chk_eq($sformatf("hold.busy%0d", i), 32'(busy_a), 32'(exp_busy[i]));
         chk_eq($sformatf("hold.ack%0d", i),  32'(ack_a),  32'(exp_ack[i]));
         if (i == 3) chk_eq("hold.dout1", dout_a, 32'hCAFE_0008);
         if (i == 7) begin
            chk_eq("hold.dout2", dout_a, 32'hCAFE_000C);
            req_a = 1'b0;
         end
      end
      @(negedge clk);
      chk_eq("hold.idle", 32'(busy_a), 32'd0);

      // Reset during WAIT of a write aborts it
      acc(0, 1'b1, 32'h20, 32'h0000_0020, 1'b0, 32'hCAFE_000C, "wr20");
      @(negedge clk);
      rw = 1'b1; addr = 32'h20; din = 32'hA5A5_A5A5; req_a = 1'b1;
      @(negedge clk);
      req_a = 1'b0;
      chk_eq("abort.busy_pre", 32'(busy_a), 32'd1);
      #2 rst_a = 1'b0;
      #1;
      chk_eq("abort.busy", 32'(busy_a), 32'd0);
      chk_eq("abort.ack",  32'(ack_a),  32'd0);
      chk_eq("abort.dout", dout_a,      32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_a = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk_eq($sformatf("abort.noack%0d", i), {30'd0, ack_a, busy_a}, 32'd0);
      end
      acc(0, 1'b0, 32'h20, 32'h0, 1'b0, 32'h0000_0020, "rd20");

      // Zero wait states; word 0 written before a reset and read after it
      acc(1, 1'b1, 32'h0, 32'h5A5A_0000, 1'b0, 32'h0, "b.wr00");
      @(negedge clk);
      rst_b = 1'b0;
      @(negedge clk);
      chk_eq("b.rst.dout", dout_b, 32'd0);
      rst_b = 1'b1;
      acc(1, 1'b0, 32'h0, 32'h0, 1'b0, 32'h5A5A_0000, "b.rd00");
      acc(1, 1'b0, 32'h3, 32'h0, 1'b1, 32'h5A5A_0000, "b.rd03mis");

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
